// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit-path arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 4;

  // One-hot pick of the first valid index strictly after ptr, wrapping modulo num.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [1:0]         ptr,
                                                 input int unsigned        num);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (!found && k <= num) begin
        idx = (int'(ptr) + k) % num;
        if (valid[idx[1:0]]) begin
          pick[idx[1:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin select over the requester valid lines.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic [MAX_REQ-1:0] pick_all;

  always_comb begin
    pick_all = rr_pick(MAX_REQ'(valid), ptr, unsigned'(NUM_REQ));
  end

  assign pick = pick_all[NUM_REQ-1:0];
  assign any  = |pick_all;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART TX FIFO,
// with a baud-timed inter-packet gap and stalled-owner reclaim.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int GAP_TICKS     = 160,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_16_x_baud,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_write,
  input  logic                      tx_buffer_full,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_TICKS);
  localparam logic [GW-1:0] G_LIM = GW'(GAP_TICKS);
  localparam state_t AFTER_PKT = (GAP_TICKS > 0) ? GAP : IDLE;

  state_t              state;
  logic [1:0]          ptr;
  logic [TW-1:0]       tcnt;
  logic [GW-1:0]       gcnt;
  logic [NUM_REQ-1:0]  pick;
  logic                any;
  logic [1:0]          pick_idx;
  logic [BYTE_W-1:0]   sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic                xfer;
  logic [TW-1:0]       tcnt_inc;
  logic [GW-1:0]       gcnt_inc;
  logic [GW-1:0]       gap_start;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (req_valid),
    .ptr   (ptr),
    .pick  (pick),
    .any   (any)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    pick_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[i*BYTE_W +: BYTE_W];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
      if (pick[i]) pick_idx = 2'(i);
    end
  end

  // tx_write doubles as the write-pending flag: one byte per two clocks.
  assign req_ready = (state == XFER && !tx_buffer_full && !tx_write) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  assign tcnt_inc  = (tcnt == T_LIM) ? tcnt : tcnt + 1'b1;
  assign gcnt_inc  = (gcnt == G_LIM) ? gcnt : gcnt + GW'(en_16_x_baud);
  // A tick on the entry edge counts as the first gap tick.
  assign gap_start = GW'(en_16_x_baud);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= 2'(NUM_REQ - 1);
      tcnt        <= '0;
      gcnt        <= '0;
      tx_data     <= '0;
      tx_write    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_write    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant <= pick;
            ptr   <= pick_idx;
            tcnt  <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (xfer) begin
            tx_data  <= sel_data;
            tx_write <= 1'b1;
            tcnt     <= '0;
            if (sel_last) begin
              grant <= '0;
              gcnt  <= gap_start;
              state <= AFTER_PKT;
            end
          end else if (!sel_valid && en_16_x_baud) begin
            tcnt <= tcnt_inc;
            if (tcnt_inc >= T_LIM) begin
              timeout_err <= 1'b1;
              grant       <= '0;
              gcnt        <= gap_start;
              state       <= AFTER_PKT;
            end
          end
        end
        GAP: begin
          gcnt <= gcnt_inc;
          if (gcnt_inc >= G_LIM) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
